// File: rtl/axis_switch_pkg.sv
// ---------------------------------------------------------------------------
// axis_switch_pkg
// Shared types and constants for the N-to-1 AXI4-Stream video switcher.
//   sw_state_e  : PASS (forwarding frames) / ALIGN (hunting for a SOF)
//   DROP_CNT_W  : width of the alignment drop counter
//   sat_inc()   : saturating increment used by the drop counter
// ---------------------------------------------------------------------------
package axis_switch_pkg;

    typedef enum logic {
        PASS  = 1'b0,
        ALIGN = 1'b1
    } sw_state_e;

    localparam int DROP_CNT_W = 16;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (v == '1) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/axis_switcher_nto1_if.sv
// ---------------------------------------------------------------------------
// axis_switcher_nto1_if
// Bundles the NUM_IN input streams and the single output stream of the
// switcher.
//   s_tvalid/s_tdata/s_tlast/s_tuser/s_tready : packed input streams,
//                                               input i at [i*DATA_W +: DATA_W]
//   m_tvalid/m_tdata/m_tlast/m_tuser/m_tready : output stream
// Modports:
//   slave  : switcher side (sinks the inputs, sources the output)
//   master : environment side (sources the inputs, sinks the output)
// ---------------------------------------------------------------------------
interface axis_switcher_nto1_if #(
    parameter int NUM_IN = 4,
    parameter int DATA_W = 16
);
    logic [NUM_IN-1:0]        s_tvalid;
    logic [NUM_IN*DATA_W-1:0] s_tdata;
    logic [NUM_IN-1:0]        s_tlast;
    logic [NUM_IN-1:0]        s_tuser;
    logic [NUM_IN-1:0]        s_tready;

    logic                     m_tvalid;
    logic [DATA_W-1:0]        m_tdata;
    logic                     m_tlast;
    logic                     m_tuser;
    logic                     m_tready;

    modport slave (
        input  s_tvalid, s_tdata, s_tlast, s_tuser, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast, m_tuser
    );

    modport master (
        output s_tvalid, s_tdata, s_tlast, s_tuser, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast, m_tuser
    );
endinterface

// File: rtl/sync_edge_detect.sv
// ---------------------------------------------------------------------------
// sync_edge_detect
// Registers a synchronous level and flags its rising edge for one cycle.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   d     : synchronous level input
//   rise  : high for the cycle in which d is 1 and was 0 the cycle before
// ---------------------------------------------------------------------------
module sync_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);
    logic d_d;
    logic d_q;

    always_comb d_d = d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) d_q <= 1'b0;
        else        d_q <= d_d;
    end

    assign rise = d & ~d_q;
endmodule

// File: rtl/axis_switcher_nto1.sv
// ---------------------------------------------------------------------------
// axis_switcher_nto1
// N-to-1 AXI4-Stream video switcher. Source changes are only applied on frame
// boundaries: the outgoing source is cut just before its SOF beat, and the new
// source is forwarded starting from its own SOF, so no torn frame leaves.
//   clk, rstn      : clock, asynchronous active-low reset
//   axis           : input streams / output stream (slave modport)
//   sel_req        : one-cycle strobe requesting source sel_idx
//   sel_idx        : requested source index
//   btn_next       : level; each rising edge requests the next source
//   active_sel     : source currently owning the output
//   switch_pending : a request is latched and waiting for a frame boundary
//   sel_err        : one-cycle pulse for an out-of-range sel_idx
//   drop_cnt       : saturating count of beats discarded while aligning
// ---------------------------------------------------------------------------
module axis_switcher_nto1
    import axis_switch_pkg::*;
#(
    parameter int NUM_IN           = 4,
    parameter int DATA_W           = 16,
    parameter int SEL_W            = $clog2(NUM_IN),
    parameter int RESET_SEL        = 0,
    parameter int FLUSH_UNSELECTED = 1
) (
    input  logic                  clk,
    input  logic                  rstn,
    axis_switcher_nto1_if.slave   axis,
    input  logic                  sel_req,
    input  logic [SEL_W-1:0]      sel_idx,
    input  logic                  btn_next,
    output logic [SEL_W-1:0]      active_sel,
    output logic                  switch_pending,
    output logic                  sel_err,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

    // Next index after v, wrapping NUM_IN-1 back to 0.
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
        if ({1'b0, v} == NUM_IN_W - (SEL_W+1)'(1)) return '0;
        return v + SEL_W'(1);
    endfunction

    sw_state_e             state_q,          state_d;
    logic [SEL_W-1:0]      active_sel_q,     active_sel_d;
    logic [SEL_W-1:0]      pending_idx_q,    pending_idx_d;
    logic                  switch_pending_q, switch_pending_d;
    logic                  sel_err_q,        sel_err_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q,       drop_cnt_d;
    logic                  stalled_q,        stalled_d;

    logic                  btn_rise;
    logic                  cur_valid;
    logic                  cur_user;
    logic                  cur_last;
    logic [DATA_W-1:0]     cur_data;
    logic                  switch_now;
    logic                  m_tvalid_c;
    logic [NUM_IN-1:0]     s_tready_c;
    logic                  idx_ok;
    logic                  req_hit;
    logic [SEL_W-1:0]      req_idx;
    logic [SEL_W-1:0]      btn_target;

    sync_edge_detect u_btn_edge (
        .clk   (clk),
        .rst_n (rstn),
        .d     (btn_next),
        .rise  (btn_rise)
    );

    // Output path: a pure mux off the registered selection, zero latency.
    always_comb begin
        cur_valid = axis.s_tvalid[active_sel_q];
        cur_user  = axis.s_tuser[active_sel_q];
        cur_last  = axis.s_tlast[active_sel_q];
        cur_data  = axis.s_tdata[active_sel_q*DATA_W +: DATA_W];

        // Cut point: hold the old source's SOF back, unless that beat was
        // already offered downstream and must complete first.
        switch_now = (state_q == PASS) && switch_pending_q && cur_valid &&
                     cur_user && !stalled_q;

        m_tvalid_c = (state_q == PASS) && cur_valid && !switch_now;

        s_tready_c = (FLUSH_UNSELECTED != 0) ? '1 : '0;
        if (state_q == PASS)
            s_tready_c[active_sel_q] = axis.m_tready && !switch_now;
        else
            s_tready_c[active_sel_q] = cur_valid && !cur_user;
        if (!rstn)
            s_tready_c = '0;
    end

    assign axis.m_tvalid = m_tvalid_c;
    assign axis.m_tdata  = cur_data;
    assign axis.m_tlast  = cur_last;
    assign axis.m_tuser  = cur_user;
    assign axis.s_tready = s_tready_c;

    // Request decode and state update.
    always_comb begin
        state_d          = state_q;
        active_sel_d     = active_sel_q;
        pending_idx_d    = pending_idx_q;
        switch_pending_d = switch_pending_q;
        drop_cnt_d       = drop_cnt_q;
        stalled_d        = m_tvalid_c & ~axis.m_tready;

        idx_ok     = ({1'b0, sel_idx} < NUM_IN_W);
        sel_err_d  = sel_req && !idx_ok;
        btn_target = switch_pending_q ? pending_idx_q : active_sel_q;

        // An explicit index beats the button when both arrive together.
        req_hit = 1'b0;
        req_idx = '0;
        if (sel_req && idx_ok) begin
            req_hit = 1'b1;
            req_idx = sel_idx;
        end else if (btn_rise) begin
            req_hit = 1'b1;
            req_idx = wrap_inc(btn_target);
        end

        case (state_q)
            PASS: begin
                if (switch_now) begin
                    // A request landing on the cut cycle is the newest wish.
                    state_d          = ALIGN;
                    switch_pending_d = 1'b0;
                    active_sel_d     = req_hit ? req_idx : pending_idx_q;
                end else if (req_hit) begin
                    if (req_idx == active_sel_q) begin
                        switch_pending_d = 1'b0;
                    end else begin
                        pending_idx_d    = req_idx;
                        switch_pending_d = 1'b1;
                    end
                end
            end
            ALIGN: begin
                if (cur_valid && !cur_user)
                    drop_cnt_d = sat_inc(drop_cnt_q);
                // Nothing is being forwarded, so a request can retarget now.
                if (req_hit) begin
                    active_sel_d     = req_idx;
                    switch_pending_d = 1'b0;
                end else if (cur_valid && cur_user) begin
                    state_d = PASS;
                end
            end
            default: state_d = ALIGN;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q          <= ALIGN;
            active_sel_q     <= SEL_W'(RESET_SEL);
            pending_idx_q    <= SEL_W'(RESET_SEL);
            switch_pending_q <= 1'b0;
            sel_err_q        <= 1'b0;
            drop_cnt_q       <= '0;
            stalled_q        <= 1'b0;
        end else begin
            state_q          <= state_d;
            active_sel_q     <= active_sel_d;
            pending_idx_q    <= pending_idx_d;
            switch_pending_q <= switch_pending_d;
            sel_err_q        <= sel_err_d;
            drop_cnt_q       <= drop_cnt_d;
            stalled_q        <= stalled_d;
        end
    end

    assign active_sel     = active_sel_q;
    assign switch_pending = switch_pending_q;
    assign sel_err        = sel_err_q;
    assign drop_cnt       = drop_cnt_q;

endmodule
